// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD panel serial interface.
// Defines the RS encodings, sequencer command codes and FSM states.
package lcd_pkg;

    localparam int   DATA_WIDTH = 8;
    localparam logic RS_CMD     = 1'b0;
    localparam logic RS_DATA    = 1'b1;

    typedef enum logic [3:0] {
        INITIAL,
        SLEEP_OUT,
        PIXEL_FORMAT,
        MEM_ACCESS,
        COLUMN_SET,
        PAGE_SET,
        DISPLAY_ON,
        WRITE_MEMORY,
        SHOW_IMAGE
    } lcd_cmd_t;

    typedef enum logic [2:0] {
        POR_LOW,
        POR_WAIT,
        IDLE,
        SHIFT,
        HOLD,
        GAP
    } lcd_state_t;

endpackage

// File: rtl/lcd_por_seq.sv
// Panel power-on reset timing: holds rst_lcd low, then waits before traffic.
// Also turns on the backlight once the panel leaves reset.
module lcd_por_seq
    import lcd_pkg::*;
#(
    parameter int RST_LOW_CYCLES  = 1000,
    parameter int RST_WAIT_CYCLES = 2000
) (
    input  logic clk,
    input  logic rst,
    output logic rst_lcd,
    output logic led_lcd,
    output logic por_done
);

    localparam int MAX_CYCLES = (RST_LOW_CYCLES > RST_WAIT_CYCLES) ? RST_LOW_CYCLES : RST_WAIT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(RST_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RST_WAIT_CYCLES - 1);

    lcd_state_t       phase;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase   <= POR_LOW;
            cnt     <= '0;
            rst_lcd <= 1'b0;
            led_lcd <= 1'b0;
        end else begin
            case (phase)
                POR_LOW: begin
                    if (cnt == LOW_LAST) begin
                        phase   <= POR_WAIT;
                        cnt     <= '0;
                        rst_lcd <= 1'b1;
                        led_lcd <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                POR_WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        phase <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Raised during the final wait cycle so the serializer leaves POR exactly on time.
    assign por_done = (phase == IDLE) || ((phase == POR_WAIT) && (cnt == WAIT_LAST));

endmodule

// File: rtl/lcd_spi_tx.sv
// 4-wire SPI byte transmitter for an ILI9341-class panel with a one-deep request slot.
// Serializer FSM, SCL divider and pending slot live here; POR timing is delegated.
module lcd_spi_tx
    import lcd_pkg::*;
#(
    parameter int DATA_WIDTH      = lcd_pkg::DATA_WIDTH,
    parameter int CLK_DIV         = 4,
    parameter int RST_LOW_CYCLES  = 1000,
    parameter int RST_WAIT_CYCLES = 2000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  index_or_data,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  done,
    output logic                  busy,
    output logic                  overrun,
    output logic                  rst_lcd,
    output logic                  scl_lcd,
    output logic                  sda_lcd,
    output logic                  cs_lcd,
    output logic                  rs_lcd,
    output logic                  led_lcd
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(DATA_WIDTH - 1);

    lcd_state_t            state;
    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] slot_data;
    logic                  slot_rs;
    logic                  slot_full;
    logic                  por_done;
    logic                  div_last;
    logic                  capture;
    logic                  take;
    logic                  slot_next;
    logic                  going_idle;

    lcd_por_seq #(
        .RST_LOW_CYCLES (RST_LOW_CYCLES),
        .RST_WAIT_CYCLES(RST_WAIT_CYCLES)
    ) u_por (
        .clk     (clk),
        .rst     (rst),
        .rst_lcd (rst_lcd),
        .led_lcd (led_lcd),
        .por_done(por_done)
    );

    assign div_last = (div_cnt == DIV_LAST);
    assign capture  = valid_in && !slot_full;
    // A queued word is launched from IDLE, or straight from the end of GAP to keep CS-high minimal.
    assign take       = slot_full && ((state == IDLE) || ((state == GAP) && div_last));
    assign slot_next  = capture || (slot_full && !take);
    assign going_idle = ((state inside {POR_LOW, POR_WAIT}) && por_done)
                     || ((state == IDLE) && !slot_full)
                     || ((state == GAP) && div_last && !slot_full);

    // The shift register MSB drives the data pin directly, so SDA is a flop output.
    assign sda_lcd = shreg[DATA_WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= POR_LOW;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            slot_data <= '0;
            slot_rs   <= RS_CMD;
            slot_full <= 1'b0;
            scl_lcd   <= 1'b0;
            cs_lcd    <= 1'b1;
            rs_lcd    <= RS_CMD;
            done      <= 1'b0;
            busy      <= 1'b1;
            overrun   <= 1'b0;
        end else begin
            done      <= 1'b0;
            busy      <= !(going_idle && !slot_next);
            slot_full <= slot_next;
            if (capture) begin
                slot_data <= data_in;
                slot_rs   <= index_or_data;
            end
            if (valid_in && slot_full) begin
                overrun <= 1'b1;
            end

            if (take) begin
                state   <= SHIFT;
                shreg   <= slot_data;
                rs_lcd  <= slot_rs;
                cs_lcd  <= 1'b0;
                scl_lcd <= 1'b0;
                div_cnt <= '0;
                bit_cnt <= BIT_TOP;
            end else begin
                case (state)
                    POR_LOW, POR_WAIT: begin
                        if (por_done) begin
                            state <= IDLE;
                        end
                    end
                    IDLE: ;
                    SHIFT: begin
                        if (!div_last) begin
                            div_cnt <= div_cnt + 1'b1;
                        end else begin
                            div_cnt <= '0;
                            if (!scl_lcd) begin
                                scl_lcd <= 1'b1;
                            end else begin
                                scl_lcd <= 1'b0;
                                if (bit_cnt == '0) begin
                                    state <= HOLD;
                                end else begin
                                    bit_cnt <= bit_cnt - 1'b1;
                                    shreg   <= {shreg[DATA_WIDTH-2:0], 1'b0};
                                end
                            end
                        end
                    end
                    HOLD: begin
                        if (!div_last) begin
                            div_cnt <= div_cnt + 1'b1;
                        end else begin
                            div_cnt <= '0;
                            cs_lcd  <= 1'b1;
                            done    <= 1'b1;
                            state   <= GAP;
                        end
                    end
                    GAP: begin
                        if (!div_last) begin
                            div_cnt <= div_cnt + 1'b1;
                        end else begin
                            div_cnt <= '0;
                            state   <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
